// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter
// Round-robin arbiter sharing one AXI4 write master port (AW/W/B) between
// NUM_REQ requesters. A grant is held for one whole write transaction:
// the AW handshake, every W beat, then the B handshake.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   s_aw*, s_w*, s_b*  per-requester AXI write channels, flattened
//                      (requester i owns slice i of each bus)
//   m_aw*, m_w*, m_b*  shared AXI write master port
//   grant_idx          current or last granted requester
//   busy               high whenever the FSM is not IDLE
//   err_wlast          one-cycle pulse on a W handshake whose wlast does not
//                      match the beat count implied by awlen
//   dbg_state          FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 RESP)
//
// Handshake rule on every channel: a transfer happens in a cycle where
// valid and ready are both high. The granted requester's valid/payload are
// muxed straight onto the master port and the master's ready/response are
// muxed straight back, so the arbiter adds no extra handshake stage.
module axi_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GW      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ*32-1:0] s_awaddr,
  input  logic [NUM_REQ*8-1:0]  s_awlen,
  input  logic [NUM_REQ*3-1:0]  s_awsize,
  input  logic [NUM_REQ*2-1:0]  s_awburst,
  input  logic [NUM_REQ-1:0]    s_awvalid,
  output logic [NUM_REQ-1:0]    s_awready,
  input  logic [NUM_REQ*32-1:0] s_wdata,
  input  logic [NUM_REQ*4-1:0]  s_wstrb,
  input  logic [NUM_REQ-1:0]    s_wlast,
  input  logic [NUM_REQ-1:0]    s_wvalid,
  output logic [NUM_REQ-1:0]    s_wready,
  output logic [NUM_REQ*2-1:0]  s_bresp,
  output logic [NUM_REQ-1:0]    s_bvalid,
  input  logic [NUM_REQ-1:0]    s_bready,
  output logic [31:0]           m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [GW-1:0]         grant_idx,
  output logic                  busy,
  output logic                  err_wlast,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last;
  logic [7:0]    r_beat;
  logic [7:0]    r_len;

  int            w_g;
  logic [GW-1:0] w_winner;
  logic          w_found;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_b_hs;
  logic          w_at_len;

  assign w_g = int'(r_grant);

  // Round-robin pick: scan starting one past the last granted requester.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && s_awvalid[idx]) begin
        w_winner = GW'(idx);
        w_found  = 1'b1;
      end
    end
  end

  // Channel muxing. Each channel is only connected in its own state, so W
  // can never slip through during the AW handshake cycle.
  always_comb begin
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awsize  = '0;
    m_awburst = '0;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = '0;
    case (r_state)
      S_ADDR: begin
        m_awaddr  = s_awaddr[32*w_g +: 32];
        m_awlen   = s_awlen[8*w_g +: 8];
        m_awsize  = s_awsize[3*w_g +: 3];
        m_awburst = s_awburst[2*w_g +: 2];
        m_awvalid = s_awvalid[w_g];
        for (int i = 0; i < NUM_REQ; i++) begin
          if (i == w_g) s_awready[i] = m_awready;
        end
      end
      S_DATA: begin
        m_wdata  = s_wdata[32*w_g +: 32];
        m_wstrb  = s_wstrb[4*w_g +: 4];
        m_wlast  = s_wlast[w_g];
        m_wvalid = s_wvalid[w_g];
        for (int i = 0; i < NUM_REQ; i++) begin
          if (i == w_g) s_wready[i] = m_wready;
        end
      end
      S_RESP: begin
        m_bready = s_bready[w_g];
        for (int i = 0; i < NUM_REQ; i++) begin
          if (i == w_g) begin
            s_bvalid[i]         = m_bvalid;
            s_bresp[2*i +: 2]   = m_bresp;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_aw_hs  = (r_state == S_ADDR) && m_awvalid && m_awready;
  assign w_w_hs   = (r_state == S_DATA) && m_wvalid && m_wready;
  assign w_b_hs   = (r_state == S_RESP) && m_bvalid && m_bready;
  assign w_at_len = (r_beat == r_len);

  // wlast must be high exactly on the beat where the count reaches awlen.
  assign err_wlast = w_w_hs && (m_wlast != w_at_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= GW'(NUM_REQ - 1);
      r_beat  <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_aw_hs) begin
            r_len   <= m_awlen;
            r_beat  <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_w_hs) begin
            r_beat <= r_beat + 8'd1;
            // A missing wlast still ends the burst at the awlen count.
            if (m_wlast || w_at_len) r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_b_hs) begin
            r_last  <= r_grant;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_idx = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
module tb_axi_wr_arbiter;

  localparam int NUM_REQ = 2;
  localparam int GW      = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ*32-1:0] s_awaddr = '0;
  logic [NUM_REQ*8-1:0]  s_awlen = '0;
  logic [NUM_REQ*3-1:0]  s_awsize = '0;
  logic [NUM_REQ*2-1:0]  s_awburst = '0;
  logic [NUM_REQ-1:0]    s_awvalid = '0;
  logic [NUM_REQ-1:0]    s_awready;
  logic [NUM_REQ*32-1:0] s_wdata = '0;
  logic [NUM_REQ*4-1:0]  s_wstrb = '0;
  logic [NUM_REQ-1:0]    s_wlast = '0;
  logic [NUM_REQ-1:0]    s_wvalid = '0;
  logic [NUM_REQ-1:0]    s_wready;
  logic [NUM_REQ*2-1:0]  s_bresp;
  logic [NUM_REQ-1:0]    s_bvalid;
  logic [NUM_REQ-1:0]    s_bready = '0;
  logic [31:0]           m_awaddr;
  logic [7:0]            m_awlen;
  logic [2:0]            m_awsize;
  logic [1:0]            m_awburst;
  logic                  m_awvalid;
  logic                  m_awready = 1'b0;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wstrb;
  logic                  m_wlast;
  logic                  m_wvalid;
  logic                  m_wready = 1'b0;
  logic [1:0]            m_bresp = '0;
  logic                  m_bvalid = 1'b0;
  logic                  m_bready;
  logic [GW-1:0]         grant_idx;
  logic                  busy;
  logic                  err_wlast;
  logic [1:0]            dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  axi_wr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .grant_idx(grant_idx), .busy(busy), .err_wlast(err_wlast),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full transaction for requester req, starting from IDLE.
  //   nbeats   beats driven before RESP is expected
  //   wlast_at beat (1-based) that carries wlast, 0 for never
  //   err_at   beat on which err_wlast must pulse, 0 for never
  //   aw_stall cycles of m_awready low in ADDR
  //   w_toggle insert one m_wready-low cycle before every beat
  //   hold_aw  keep s_awvalid[req] asserted after the AW handshake
  task automatic txn(input int req, input logic [31:0] addr,
                     input logic [7:0] len, input int nbeats,
                     input int wlast_at, input int err_at,
                     input int aw_stall, input bit w_toggle,
                     input bit hold_aw);
    logic [NUM_REQ-1:0]   one;
    logic [NUM_REQ*2-1:0] exp_bresp;
    logic [1:0]           resp;
    one       = NUM_REQ'(1) << req;
    resp      = 2'(req + 1);
    exp_bresp = (NUM_REQ*2)'(resp) << (2 * req);

    s_awaddr[32*req +: 32] = addr;
    s_awlen[8*req +: 8]    = len;
    s_awsize[3*req +: 3]   = 3'd2;
    s_awburst[2*req +: 2]  = 2'b01;
    s_awvalid[req]         = 1'b1;
    m_awready              = (aw_stall == 0);
    #1;
    check_eq("idle_no_awvalid", 64'(m_awvalid), 64'(0));
    step();
    check_eq("grant_idx", 64'(grant_idx), 64'(req));
    check_eq("state_addr", 64'(dbg_state), 64'(ST_ADDR));
    check_eq("m_awvalid", 64'(m_awvalid), 64'(1));
    check_eq("m_awaddr", 64'(m_awaddr), 64'(addr));
    check_eq("m_awlen", 64'(m_awlen), 64'(len));
    check_eq("m_awsize_burst", 64'({m_awsize, m_awburst}), 64'({3'd2, 2'b01}));
    for (int c = 0; c < aw_stall; c++) begin
      check_eq("aw_stall_ready", 64'(s_awready), 64'(0));
      check_eq("aw_stall_addr", 64'(m_awaddr), 64'(addr));
      check_eq("aw_stall_state", 64'(dbg_state), 64'(ST_ADDR));
      step();
    end
    m_awready = 1'b1;
    #1;
    check_eq("s_awready", 64'(s_awready), 64'(one));
    check_eq("no_w_in_addr", 64'(m_wvalid), 64'(0));
    step();
    if (!hold_aw) s_awvalid[req] = 1'b0;
    m_awready = 1'b0;
    check_eq("state_data", 64'(dbg_state), 64'(ST_DATA));
    check_eq("awvalid_off_in_data", 64'(m_awvalid), 64'(0));

    for (int b = 1; b <= nbeats; b++) begin
      s_wvalid[req]          = 1'b1;
      s_wdata[32*req +: 32]  = addr + 32'(b);
      s_wstrb[4*req +: 4]    = 4'hf;
      s_wlast[req]           = (b == wlast_at);
      if (w_toggle) begin
        m_wready = 1'b0;
        #1;
        check_eq("w_stall_ready", 64'(s_wready), 64'(0));
        check_eq("w_stall_err", 64'(err_wlast), 64'(0));
        step();
        check_eq("w_stall_state", 64'(dbg_state), 64'(ST_DATA));
      end
      m_wready = 1'b1;
      #1;
      check_eq("m_wvalid", 64'(m_wvalid), 64'(1));
      check_eq("m_wdata", 64'(m_wdata), 64'(addr + 32'(b)));
      check_eq("m_wlast", 64'(m_wlast), 64'(b == wlast_at));
      check_eq("s_wready", 64'(s_wready), 64'(one));
      check_eq("err_wlast", 64'(err_wlast), 64'(b == err_at));
      step();
    end
    s_wvalid[req] = 1'b0;
    s_wlast[req]  = 1'b0;
    m_wready      = 1'b0;
    check_eq("state_resp", 64'(dbg_state), 64'(ST_RESP));
    check_eq("busy_resp", 64'(busy), 64'(1));

    m_bvalid       = 1'b1;
    m_bresp        = resp;
    s_bready[req]  = 1'b1;
    #1;
    check_eq("s_bvalid", 64'(s_bvalid), 64'(one));
    check_eq("s_bresp", 64'(s_bresp), 64'(exp_bresp));
    check_eq("m_bready", 64'(m_bready), 64'(1));
    step();
    check_eq("state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check_eq("busy_idle", 64'(busy), 64'(0));
    check_eq("s_bvalid_idle", 64'(s_bvalid), 64'(0));
    check_eq("grant_hold", 64'(grant_idx), 64'(req));
    m_bvalid      = 1'b0;
    m_bresp       = 2'b00;
    s_bready[req] = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_grant", 64'(grant_idx), 64'(0));
    check_eq("rst_valids", 64'({m_awvalid, m_wvalid, m_bready, err_wlast}), 64'(0));
    check_eq("rst_s_ready", 64'({s_awready, s_wready, s_bvalid}), 64'(0));
    check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    step();

    // Single request: 4 beats, wlast on beat 4, no error
    txn(0, 32'h10, 8'd3, 4, 4, 0, 0, 1'b0, 1'b0);

    // Fairness: both hold awvalid, single beats. Last grant was 0, so 1 wins.
    s_awvalid = 2'b11;
    txn(1, 32'h200, 8'd0, 1, 1, 0, 0, 1'b0, 1'b1);
    txn(0, 32'h100, 8'd0, 1, 1, 0, 0, 1'b0, 1'b1);
    txn(1, 32'h210, 8'd0, 1, 1, 0, 0, 1'b0, 1'b1);
    txn(0, 32'h110, 8'd0, 1, 1, 0, 0, 1'b0, 1'b1);
    s_awvalid = 2'b00;
    step();

    // Backpressure: AW stalled 3 cycles, W ready toggling
    txn(1, 32'h300, 8'd1, 2, 2, 0, 3, 1'b1, 1'b0);

    // Early wlast: awlen=2, wlast on beat 2 -> error on beat 2, RESP after it
    txn(0, 32'h400, 8'd2, 2, 2, 2, 0, 1'b0, 1'b0);

    // Missing wlast: awlen=1, never asserted -> error and forced end on beat 2
    txn(1, 32'h500, 8'd1, 2, 0, 2, 0, 1'b0, 1'b0);

    // Mid-burst reset after 1 of 4 beats
    s_awaddr[31:0] = 32'h600;
    s_awlen[7:0]   = 8'd3;
    s_awvalid[0]   = 1'b1;
    m_awready      = 1'b1;
    step();
    step();
    s_awvalid[0]   = 1'b0;
    m_awready      = 1'b0;
    check_eq("mr_state_data", 64'(dbg_state), 64'(ST_DATA));
    s_wvalid[0]    = 1'b1;
    s_wdata[31:0]  = 32'h601;
    m_wready       = 1'b1;
    step();
    s_wdata[31:0]  = 32'h602;
    #1;
    check_eq("mr_beat2_fwd", 64'(m_wvalid), 64'(1));
    reset = 1'b1;
    #1;
    check_eq("mr_busy", 64'(busy), 64'(0));
    check_eq("mr_grant", 64'(grant_idx), 64'(0));
    check_eq("mr_state", 64'(dbg_state), 64'(ST_IDLE));
    check_eq("mr_outs", 64'({m_wvalid, m_awvalid, m_bready, err_wlast}), 64'(0));
    check_eq("mr_s_ready", 64'({s_wready, s_awready, s_bvalid}), 64'(0));
    s_wvalid = '0;
    m_wready = 1'b0;
    step();
    reset = 1'b0;
    s_awvalid = 2'b11;
    step();
    check_eq("mr_first_grant", 64'(grant_idx), 64'(0));
    check_eq("mr_first_state", 64'(dbg_state), 64'(ST_ADDR));
    s_awvalid = 2'b00;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
